// File: rtl/instr_fetch.sv
// instr_fetch -- instruction fetch stage feeding the instruction register.
//
// Holds the program counter. On fetch_req (sampled only when idle) it reads one
// DW-bit word from instruction memory over a mem_req/mem_ack handshake, presents
// it on ir_data with a single-cycle ir_w strobe, then advances the PC by one or
// loads a branch target. If memory does not acknowledge within TIMEOUT request
// cycles, the fetch is abandoned and the sticky fetch_err flag is set.
//
// Ports:
//   clk        in   1   clock, rising edge
//   rst        in   1   asynchronous reset, active-low
//   fetch_req  in   1   start a fetch (sampled only in IDLE)
//   pc_load    in   1   load branch target pc_new (any state)
//   pc_new     in   AW  branch target address
//   mem_req    out  1   memory read request
//   mem_addr   out  AW  memory read address, stable while mem_req=1
//   mem_rdata  in   DW  memory read data, valid with mem_ack
//   mem_ack    in   1   memory acknowledge (only looked at in REQ)
//   ir_data    out  DW  fetched instruction
//   ir_w       out  1   IR write strobe, one cycle per successful fetch
//   pc         out  AW  program counter
//   busy       out  1   high while a fetch is in flight (REQ or WRITE)
//   fetch_err  out  1   sticky timeout flag, cleared by the next accepted fetch
module instr_fetch #(
  parameter int AW      = 10,
  parameter int DW      = 16,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fetch_req,
  input  logic          pc_load,
  input  logic [AW-1:0] pc_new,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic [DW-1:0] ir_data,
  output logic          ir_w,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          fetch_err
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0] PC_ONE   = {{(AW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_WRITE = 2'd2
  } state_e;

  state_e        state_q,     state_d;
  logic [AW-1:0] pc_q,        pc_d;
  logic [AW-1:0] mem_addr_q,  mem_addr_d;
  logic [DW-1:0] ir_data_q,   ir_data_d;
  logic [AW-1:0] pend_addr_q, pend_addr_d;
  logic          pend_vld_q,  pend_vld_d;
  logic [CW-1:0] cnt_q,       cnt_d;
  logic          fetch_err_q, fetch_err_d;
  logic          mem_req_q,   mem_req_d;
  logic          ir_w_q,      ir_w_d;
  logic          busy_q,      busy_d;
  logic [AW-1:0] addr_s;

  // Next-state and next-output computation for the fetch FSM.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    mem_addr_d  = mem_addr_q;
    ir_data_d   = ir_data_q;
    pend_addr_d = pend_addr_q;
    pend_vld_d  = pend_vld_q;
    cnt_d       = cnt_q;
    fetch_err_d = fetch_err_q;
    addr_s      = pc_load ? pc_new : pc_q;

    // A branch load while a fetch is in flight is parked until the fetch ends;
    // the latest load overwrites any earlier one.
    if (state_q != S_IDLE && pc_load) begin
      pend_addr_d = pc_new;
      pend_vld_d  = 1'b1;
    end else begin
      pend_addr_d = pend_addr_q;
    end

    case (state_q)
      S_IDLE: begin
        if (fetch_req) begin
          pc_d        = addr_s;
          mem_addr_d  = addr_s;
          cnt_d       = {CW{1'b0}};
          fetch_err_d = 1'b0;
          state_d     = S_REQ;
        end else if (pc_load) begin
          pc_d = pc_new;
        end else begin
          pc_d = pc_q;
        end
      end
      S_REQ: begin
        if (mem_ack) begin
          ir_data_d = mem_rdata;
          state_d   = S_WRITE;
        end else if (cnt_q == CNT_LAST) begin
          // Timeout: abandon the fetch; a load arriving on this very edge wins.
          pc_d        = pc_load ? pc_new : (pend_vld_q ? pend_addr_q : pc_q);
          pend_vld_d  = 1'b0;
          fetch_err_d = 1'b1;
          state_d     = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_WRITE: begin
        // Increment wraps naturally at 2^AW-1.
        pc_d       = pc_load ? pc_new : (pend_vld_q ? pend_addr_q : pc_q + PC_ONE);
        pend_vld_d = 1'b0;
        state_d    = S_IDLE;
      end
      default: begin
        state_d    = S_IDLE;
        pend_vld_d = 1'b0;
      end
    endcase

    // Moore outputs registered from the next state.
    mem_req_d = (state_d == S_REQ);
    ir_w_d    = (state_d == S_WRITE);
    busy_d    = (state_d != S_IDLE);
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      pc_q        <= {AW{1'b0}};
      mem_addr_q  <= {AW{1'b0}};
      ir_data_q   <= {DW{1'b0}};
      pend_addr_q <= {AW{1'b0}};
      pend_vld_q  <= 1'b0;
      cnt_q       <= {CW{1'b0}};
      fetch_err_q <= 1'b0;
      mem_req_q   <= 1'b0;
      ir_w_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      mem_addr_q  <= mem_addr_d;
      ir_data_q   <= ir_data_d;
      pend_addr_q <= pend_addr_d;
      pend_vld_q  <= pend_vld_d;
      cnt_q       <= cnt_d;
      fetch_err_q <= fetch_err_d;
      mem_req_q   <= mem_req_d;
      ir_w_q      <= ir_w_d;
      busy_q      <= busy_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign ir_data   = ir_data_q;
  assign ir_w      = ir_w_q;
  assign pc        = pc_q;
  assign busy      = busy_q;
  assign fetch_err = fetch_err_q;

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch -- directed self-checking bench for instr_fetch.
module tb_instr_fetch;

  logic        clk;
  logic        rst;
  logic        fetch_req;
  logic        pc_load;
  logic [9:0]  pc_new;
  logic        mem_req;
  logic [9:0]  mem_addr;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic [15:0] ir_data;
  logic        ir_w;
  logic [9:0]  pc;
  logic        busy;
  logic        fetch_err;

  int checks;
  int errors;
  int req_cnt;
  int irw_cnt;

  instr_fetch #(.AW(10), .DW(16), .TIMEOUT(15)) dut (
    .clk       (clk),
    .rst       (rst),
    .fetch_req (fetch_req),
    .pc_load   (pc_load),
    .pc_new    (pc_new),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .ir_data   (ir_data),
    .ir_w      (ir_w),
    .pc        (pc),
    .busy      (busy),
    .fetch_err (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample outputs on the falling edge.
  task automatic step();
    @(negedge clk);
    req_cnt += int'(mem_req);
    irw_cnt += int'(ir_w);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    req_cnt   = 0;
    irw_cnt   = 0;
    rst       = 1'b0;
    fetch_req = 1'b0;
    pc_load   = 1'b0;
    pc_new    = 10'h000;
    mem_rdata = 16'h0000;
    mem_ack   = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    step();

    // Reset state
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_ir_w", 32'(ir_w), 32'd0);
    chk("rst_err", 32'(fetch_err), 32'd0);

    // 1. Immediate ack
    fetch_req = 1'b1; mem_ack = 1'b1; mem_rdata = 16'hA5C3;
    step();
    fetch_req = 1'b0;
    chk("t1_mem_req", 32'(mem_req), 32'd1);
    chk("t1_mem_addr", 32'(mem_addr), 32'h000);
    chk("t1_busy", 32'(busy), 32'd1);
    step();
    mem_ack = 1'b0;
    chk("t1_ir_w", 32'(ir_w), 32'd1);
    chk("t1_ir_data", 32'(ir_data), 32'hA5C3);
    chk("t1_req_low", 32'(mem_req), 32'd0);
    step();
    chk("t1_ir_w_done", 32'(ir_w), 32'd0);
    chk("t1_busy_done", 32'(busy), 32'd0);
    chk("t1_pc", 32'(pc), 32'h001);

    // 2. Branch load to 3FF then fetch; pc wraps to 0
    pc_load = 1'b1; pc_new = 10'h3FF;
    step();
    pc_load = 1'b0;
    chk("t2_pc_load", 32'(pc), 32'h3FF);
    fetch_req = 1'b1; mem_ack = 1'b1; mem_rdata = 16'h1234;
    step();
    fetch_req = 1'b0;
    chk("t2_mem_addr", 32'(mem_addr), 32'h3FF);
    step();
    mem_ack = 1'b0;
    chk("t2_ir_data", 32'(ir_data), 32'h1234);
    step();
    chk("t2_pc_wrap", 32'(pc), 32'h000);

    // 3. Ack delayed 4 cycles; fetch_req pulse while busy is dropped
    req_cnt = 0; irw_cnt = 0;
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    chk("t3_addr_a", 32'(mem_addr), 32'h000);
    step();
    fetch_req = 1'b1;
    chk("t3_addr_b", 32'(mem_addr), 32'h000);
    step();
    fetch_req = 1'b0;
    step();
    chk("t3_addr_c", 32'(mem_addr), 32'h000);
    chk("t3_req_hold", 32'(mem_req), 32'd1);
    mem_ack = 1'b1; mem_rdata = 16'hBEEF;
    step();
    mem_ack = 1'b0;
    chk("t3_req_cycles", 32'(req_cnt), 32'd4);
    chk("t3_ir_w", 32'(ir_w), 32'd1);
    chk("t3_ir_data", 32'(ir_data), 32'hBEEF);
    repeat (6) step();
    chk("t3_no_refetch", 32'(req_cnt), 32'd4);
    chk("t3_single_ir_w", 32'(irw_cnt), 32'd1);
    chk("t3_pc", 32'(pc), 32'h001);
    chk("t3_idle", 32'(busy), 32'd0);

    // 4. Timeout
    req_cnt = 0; irw_cnt = 0;
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    repeat (20) step();
    chk("t4_req_cycles", 32'(req_cnt), 32'd15);
    chk("t4_no_ir_w", 32'(irw_cnt), 32'd0);
    chk("t4_err", 32'(fetch_err), 32'd1);
    chk("t4_pc", 32'(pc), 32'h001);
    chk("t4_busy", 32'(busy), 32'd0);
    fetch_req = 1'b1; mem_ack = 1'b1; mem_rdata = 16'h1111;
    step();
    fetch_req = 1'b0;
    chk("t4_err_clear", 32'(fetch_err), 32'd0);
    chk("t4_addr", 32'(mem_addr), 32'h001);
    step();
    mem_ack = 1'b0;
    step();
    chk("t4_pc_next", 32'(pc), 32'h002);

    // 5. Two branch loads during REQ; latest wins, word still delivered
    irw_cnt = 0;
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0; pc_load = 1'b1; pc_new = 10'h040;
    step();
    pc_new = 10'h080;
    step();
    pc_load = 1'b0;
    chk("t5_pc_held", 32'(pc), 32'h002);
    chk("t5_addr", 32'(mem_addr), 32'h002);
    mem_ack = 1'b1; mem_rdata = 16'hCAFE;
    step();
    mem_ack = 1'b0;
    chk("t5_ir_w", 32'(ir_w), 32'd1);
    chk("t5_ir_data", 32'(ir_data), 32'hCAFE);
    step();
    chk("t5_pc", 32'(pc), 32'h080);
    chk("t5_irw_cnt", 32'(irw_cnt), 32'd1);

    // 6. Asynchronous reset mid-REQ
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    step();
    chk("t6_req_before", 32'(mem_req), 32'd1);
    chk("t6_addr_before", 32'(mem_addr), 32'h080);
    #2 rst = 1'b0;
    #1;
    chk("t6_req_async", 32'(mem_req), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_pc", 32'(pc), 32'h000);
    chk("t6_addr", 32'(mem_addr), 32'h000);
    chk("t6_ir_data", 32'(ir_data), 32'h0000);
    chk("t6_ir_w", 32'(ir_w), 32'd0);
    mem_ack = 1'b1; mem_rdata = 16'h7777;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    req_cnt = 0; irw_cnt = 0;
    repeat (5) step();
    mem_ack = 1'b0;
    chk("t6_no_ir_w", 32'(irw_cnt), 32'd0);
    chk("t6_no_req", 32'(req_cnt), 32'd0);
    chk("t6_ir_data_after", 32'(ir_data), 32'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
